// File: rtl/sync_pkg.sv
// sync_pkg -- shared definitions for the pointer synchronisers.
// Holds the legal synchroniser depth range, the init FSM state type and
// Gray/binary conversion helpers. The helpers work on a fixed 32-bit word.
// Narrower pointers are zero-extended into that word, and callers keep the
// low bits of the result.
package sync_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Widest pointer (wrap bit included) the conversion helpers accept.
   localparam int PTR_W_MAX = 32;

   // The flush counter must be able to reach SYNC_STAGES_MAX.
   localparam int FLUSH_CNT_W = $clog2(SYNC_STAGES_MAX + 1);

   typedef logic [PTR_W_MAX-1:0] ptr_word_t;

   typedef enum logic {
      FLUSH = 1'b0,
      RUN   = 1'b1
   } init_state_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
      for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain -- STAGES-deep flop chain used to bring an asynchronous,
// Gray-coded bus into the clk domain. Every stage clears on rst_n.
module sync_chain
   import sync_pkg::*;
#(
   parameter int WIDTH  = 9,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   // Shift the sampled bus one stage per clock.
   // NOTE: non-blocking assignments let each stage capture its predecessor's
   // old value; blocking ones would collapse the chain into a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this array is a handful of flops, not a RAM, so it may be
         // reset; a reset discards whatever was in flight.
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync -- brings a foreign-domain Gray pointer into wrclk.
// It provides the synchronised Gray and binary pointers and the per-cycle
// advance. A small init FSM hides the chain flush after reset.
// Optional build macro: GRAY_PTR_SYNC_CHECK_EN compiles in the sticky
// Gray-code violation checker. When it is not defined, gray_err is
// tied low and err_clr is ignored.
module gray_ptr_sync
   import sync_pkg::*;
#(
   parameter int PTR_WIDTH   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               wrclk,
   input  logic               wr_rst_n,
   input  logic [PTR_WIDTH:0] rptr_gray,
   input  logic               err_clr,
   output logic [PTR_WIDTH:0] rptr_sync_gray,
   output logic [PTR_WIDTH:0] rptr_sync_bin,
   output logic               ptr_adv,
   output logic [PTR_WIDTH:0] ptr_delta,
   output logic               sync_valid,
   output logic               gray_err
);

   localparam int W = PTR_WIDTH + 1;

   // The flush count runs 0..SYNC_STAGES, which is SYNC_STAGES+1 edges.
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(SYNC_STAGES);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("gray_ptr_sync: SYNC_STAGES=%0d outside legal range %0d..%0d",
             SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
   end
   if (W > PTR_W_MAX) begin : g_bad_width
      $error("gray_ptr_sync: PTR_WIDTH=%0d too wide for sync_pkg helpers", PTR_WIDTH);
   end

   init_state_t            state, state_next;
   logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_next;
   logic [W-1:0]           bin_next;
   logic [W-1:0]           bin_prev;
   logic [W-1:0]           diff;

   sync_chain #(
      .WIDTH  (W),
      .STAGES (SYNC_STAGES)
   ) u_chain (
      .clk   (wrclk),
      .rst_n (wr_rst_n),
      .d     (rptr_gray),
      .q     (rptr_sync_gray)
   );

   // Init FSM register: state and flush counter.
   always_ff @(posedge wrclk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state     <= FLUSH;
         flush_cnt <= '0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
      end
   end

   // Init FSM next state: count out the flush, then stay in RUN until reset.
   // NOTE: defaults first, so no path leaves a signal unassigned (no latch).
   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      case (state)
         FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
               state_next = RUN;
            end else begin
               flush_cnt_next = flush_cnt + 1'b1;
            end
         end
         RUN:     state_next = RUN;
         default: state_next = FLUSH;
      endcase
   end

   assign sync_valid = (state == RUN);

   // rptr_sync_bin still holds the previous conversion when the new one is
   // formed, so it serves as bin_prev for the delta.
   assign bin_prev = rptr_sync_bin;
   assign bin_next = W'(gray2bin(ptr_word_t'(rptr_sync_gray)));
   assign diff     = bin_next - bin_prev;

   // Binary conversion and advance. The advance is suppressed until the
   // chain has flushed, so the first valid cycle never reports a
   // reset-to-pointer jump.
   always_ff @(posedge wrclk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         rptr_sync_bin <= '0;
         ptr_delta     <= '0;
         ptr_adv       <= 1'b0;
      end else begin
         rptr_sync_bin <= bin_next;
         if (state == RUN) begin
            ptr_delta <= diff;
            ptr_adv   <= |diff;
         end else begin
            ptr_delta <= '0;
            ptr_adv   <= 1'b0;
         end
      end
   end

`ifdef GRAY_PTR_SYNC_CHECK_EN
   logic [W-1:0] bit_flips;
   logic         multi_flip;
   logic         err_q;

   // Re-encoding bin_prev recovers the previous Gray value without another flop.
   assign bit_flips  = rptr_sync_gray ^ W'(bin2gray(ptr_word_t'(bin_prev)));
   assign multi_flip = |(bit_flips & (bit_flips - 1'b1));

   // Sticky violation flag; a new violation wins over a simultaneous clear.
   always_ff @(posedge wrclk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= ((state == RUN) && multi_flip) || (err_q && !err_clr);
      end
   end

   assign gray_err = err_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign gray_err       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync -- directed bench for gray_ptr_sync.
// Two instances are driven from the same stimulus, one with SYNC_STAGES=2
// and one with SYNC_STAGES=4. A history-based model predicts every output
// on every falling edge, and hand-computed literals pin key points. The
// expectations for gray_err follow GRAY_PTR_SYNC_CHECK_EN.
module tb_gray_ptr_sync;

   logic       wrclk = 1'b0;
   logic       wr_rst_n;
   logic       err_clr;
   logic [8:0] rptr_gray;

   logic [8:0] o2_sg, o2_bin, o2_delta;
   logic       o2_adv, o2_valid, o2_err;
   logic [8:0] o4_sg, o4_bin, o4_delta;
   logic       o4_adv, o4_valid, o4_err;

   int vectors     = 0;
   int miscompares = 0;

   gray_ptr_sync #(.PTR_WIDTH(8), .SYNC_STAGES(2)) dut2 (
      .wrclk          (wrclk),
      .wr_rst_n       (wr_rst_n),
      .rptr_gray      (rptr_gray),
      .err_clr        (err_clr),
      .rptr_sync_gray (o2_sg),
      .rptr_sync_bin  (o2_bin),
      .ptr_adv        (o2_adv),
      .ptr_delta      (o2_delta),
      .sync_valid     (o2_valid),
      .gray_err       (o2_err)
   );

   gray_ptr_sync #(.PTR_WIDTH(8), .SYNC_STAGES(4)) dut4 (
      .wrclk          (wrclk),
      .wr_rst_n       (wr_rst_n),
      .rptr_gray      (rptr_gray),
      .err_clr        (err_clr),
      .rptr_sync_gray (o4_sg),
      .rptr_sync_bin  (o4_bin),
      .ptr_adv        (o4_adv),
      .ptr_delta      (o4_delta),
      .sync_valid     (o4_valid),
      .gray_err       (o4_err)
   );

   always #5 wrclk = ~wrclk;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%03h, expected 0x%03h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // hist[m] is the rptr_gray value seen at the m-th rising edge after reset
   // release. n is the number of rising edges since release.
   int         n = 0;
   logic [8:0] hist [0:4095];
   logic       e2 = 1'b0;
   logic       e4 = 1'b0;

   function automatic logic [8:0] m_g2b(input logic [8:0] g);
      logic [8:0] b = '0;
      logic [8:0] s = g;
      while (s != 0) begin
         b ^= s;
         s = s >> 1;
      end
      return b;
   endfunction

   // Synchronised Gray after edge m: the input seen s edges ago.
   function automatic logic [8:0] m_sg(input int s, input int m);
      if (m < s) return '0;
      return hist[m-s+1];
   endfunction

   function automatic logic [8:0] m_bin(input int s, input int m);
      if (m < s + 1) return '0;
      return m_g2b(hist[m-s]);
   endfunction

   // The delta is reported only for edges taken while already valid.
   function automatic logic [8:0] m_delta(input int s, input int m);
      if (m < s + 2) return '0;
      return m_bin(s, m) - m_bin(s, m - 1);
   endfunction

   function automatic logic m_set(input int s, input int m);
      if (m < s + 2) return 1'b0;
      return $countones(m_sg(s, m - 1) ^ m_sg(s, m - 2)) > 1;
   endfunction

   always @(posedge wrclk) begin
      if (!wr_rst_n) begin
         n  = 0;
         e2 = 1'b0;
         e4 = 1'b0;
      end else begin
         n++;
         hist[n] = rptr_gray;
         e2 = m_set(2, n) | (e2 & ~err_clr);
         e4 = m_set(4, n) | (e4 & ~err_clr);
      end
   end

   task automatic compare_inst(input string tag, input int s,
                               input logic [8:0] sg, input logic [8:0] bin,
                               input logic [8:0] delta, input logic adv,
                               input logic valid, input logic err,
                               input logic err_model);
      logic [8:0] x_sg, x_bin, x_delta;
      logic       x_adv, x_valid, x_err;
      if (wr_rst_n) begin
         x_sg    = m_sg(s, n);
         x_bin   = m_bin(s, n);
         x_delta = m_delta(s, n);
         x_adv   = (x_delta != 0);
         x_valid = (n >= s + 1);
`ifdef GRAY_PTR_SYNC_CHECK_EN
         x_err   = err_model;
`else
         x_err   = 1'b0;
`endif
      end else begin
         x_sg = '0; x_bin = '0; x_delta = '0;
         x_adv = 1'b0; x_valid = 1'b0; x_err = 1'b0;
      end
      check({tag, ".sync_gray"}, sg, x_sg);
      check({tag, ".sync_bin"}, bin, x_bin);
      check({tag, ".ptr_delta"}, delta, x_delta);
      check({tag, ".ptr_adv"}, 9'(adv), 9'(x_adv));
      check({tag, ".sync_valid"}, 9'(valid), 9'(x_valid));
      check({tag, ".gray_err"}, 9'(err), 9'(x_err));
   endtask

   // One compare process, on the falling edge, away from the active edge.
   always @(negedge wrclk) begin
      compare_inst("s2", 2, o2_sg, o2_bin, o2_delta, o2_adv, o2_valid, o2_err, e2);
      compare_inst("s4", 4, o4_sg, o4_bin, o4_delta, o4_adv, o4_valid, o4_err, e4);
   end

   // ---------------- directed stimulus with literal pins ----------------
   initial begin
      wr_rst_n  = 1'b0;
      rptr_gray = 9'h000;
      err_clr   = 1'b0;
      repeat (2) @(negedge wrclk);
      check("rst_valid", 9'(o2_valid), 9'd0);
      check("rst_bin", o2_bin, 9'h000);
      #2 wr_rst_n = 1'b1;

      // Flush with the pointer held at 0.
      @(negedge wrclk);                                  // edge 1
      @(negedge wrclk);                                  // edge 2
      check("flush_e2_valid", 9'(o2_valid), 9'd0);
      @(negedge wrclk);                                  // edge 3
      check("flush_e3_valid", 9'(o2_valid), 9'd1);
      check("flush_e3_s4_valid", 9'(o4_valid), 9'd0);
      repeat (2) @(negedge wrclk);                       // edge 5
      check("flush_e5_s4_valid", 9'(o4_valid), 9'd1);
      check("idle_adv", 9'(o2_adv), 9'd0);
      @(negedge wrclk);                                  // edge 6

      // First advance: Gray 0x000 -> 0x001.
      rptr_gray = 9'h001;
      repeat (2) @(negedge wrclk);
      check("adv1_s2_sg", o2_sg, 9'h001);
      check("adv1_s2_bin_pre", o2_bin, 9'h000);
      @(negedge wrclk);
      check("adv1_s2_bin", o2_bin, 9'h001);
      check("adv1_s2_adv", 9'(o2_adv), 9'd1);
      check("adv1_s2_delta", o2_delta, 9'h001);
      @(negedge wrclk);
      check("adv1_s2_adv_drop", 9'(o2_adv), 9'd0);
      check("adv1_s4_sg", o4_sg, 9'h001);
      check("adv1_s4_bin_pre", o4_bin, 9'h000);
      @(negedge wrclk);
      check("adv1_s4_bin", o4_bin, 9'h001);
      check("adv1_s4_adv", 9'(o4_adv), 9'd1);
      check("adv1_s4_delta", o4_delta, 9'h001);

      // Wrap: binary 510 -> 511 -> 0.
      rptr_gray = 9'h101;
      repeat (6) @(negedge wrclk);
      check("wrap_bin510_s2", o2_bin, 9'd510);
      check("wrap_bin510_s4", o4_bin, 9'd510);
      rptr_gray = 9'h100;
      repeat (3) @(negedge wrclk);
      check("wrap_511_s2_bin", o2_bin, 9'd511);
      check("wrap_511_s2_delta", o2_delta, 9'd1);
      repeat (2) @(negedge wrclk);
      check("wrap_511_s4_delta", o4_delta, 9'd1);
      rptr_gray = 9'h000;
      repeat (3) @(negedge wrclk);
      check("wrap_0_s2_bin", o2_bin, 9'd0);
      check("wrap_0_s2_delta", o2_delta, 9'd1);
      check("wrap_0_s2_adv", 9'(o2_adv), 9'd1);
      repeat (2) @(negedge wrclk);
      check("wrap_0_s4_delta", o4_delta, 9'd1);
      check("wrap_s2_err", 9'(o2_err), 9'd0);
      check("wrap_s4_err", 9'(o4_err), 9'd0);

      // Gray violation 0x000 -> 0x003 (binary 2).
      rptr_gray = 9'h003;
      repeat (3) @(negedge wrclk);
`ifdef GRAY_PTR_SYNC_CHECK_EN
      check("jump_s2_err_set", 9'(o2_err), 9'd1);
`else
      check("jump_s2_err_off", 9'(o2_err), 9'd0);
`endif
      check("jump_s2_delta", o2_delta, 9'd2);
      repeat (3) @(negedge wrclk);
`ifdef GRAY_PTR_SYNC_CHECK_EN
      check("jump_s2_err_held", 9'(o2_err), 9'd1);
      check("jump_s4_err_set", 9'(o4_err), 9'd1);
`else
      check("jump_s4_err_off", 9'(o4_err), 9'd0);
`endif
      err_clr = 1'b1;
      @(negedge wrclk);
      err_clr = 1'b0;
      check("clr_s2_err", 9'(o2_err), 9'd0);
      check("clr_s4_err", 9'(o4_err), 9'd0);

      // New violation 0x003 -> 0x000 with err_clr on the edge that sets it.
      rptr_gray = 9'h000;
      repeat (2) @(negedge wrclk);
      err_clr = 1'b1;
      @(negedge wrclk);
      err_clr = 1'b0;
`ifdef GRAY_PTR_SYNC_CHECK_EN
      check("setclr_s2_err", 9'(o2_err), 9'd1);
`else
      check("setclr_s2_err_off", 9'(o2_err), 9'd0);
`endif
      repeat (3) @(negedge wrclk);
`ifdef GRAY_PTR_SYNC_CHECK_EN
      check("setclr_s2_err_held", 9'(o2_err), 9'd1);
      check("setclr_s4_err", 9'(o4_err), 9'd1);
`else
      check("setclr_s4_err_off", 9'(o4_err), 9'd0);
`endif

      // Mid-stream reset with rptr_sync_bin = 0x5A (Gray 0x077).
      rptr_gray = 9'h077;
      repeat (6) @(negedge wrclk);
      check("pre_rst_s2_bin", o2_bin, 9'h05A);
      check("pre_rst_s4_bin", o4_bin, 9'h05A);
      @(posedge wrclk);
      #2 wr_rst_n = 1'b0;
      #1;
      check("async_s2_sg", o2_sg, 9'h000);
      check("async_s2_bin", o2_bin, 9'h000);
      check("async_s2_valid", 9'(o2_valid), 9'd0);
      check("async_s2_err", 9'(o2_err), 9'd0);
      check("async_s4_sg", o4_sg, 9'h000);
      check("async_s4_bin", o4_bin, 9'h000);
      check("async_s4_valid", 9'(o4_valid), 9'd0);
      repeat (2) @(negedge wrclk);
      #2 wr_rst_n = 1'b1;
      @(negedge wrclk);                                  // edge 1
      @(negedge wrclk);                                  // edge 2
      check("rerun_e2_valid", 9'(o2_valid), 9'd0);
      check("rerun_e2_sg", o2_sg, 9'h077);
      @(negedge wrclk);                                  // edge 3
      check("rerun_e3_valid", 9'(o2_valid), 9'd1);
      check("rerun_e3_bin", o2_bin, 9'h05A);
      @(negedge wrclk);                                  // edge 4
      check("rerun_e4_adv", 9'(o2_adv), 9'd0);
      check("rerun_e4_delta", o2_delta, 9'h000);
      check("rerun_e4_s4_valid", 9'(o4_valid), 9'd0);
      @(negedge wrclk);                                  // edge 5
      check("rerun_e5_s4_valid", 9'(o4_valid), 9'd1);
      @(negedge wrclk);                                  // edge 6
      check("rerun_e6_s4_adv", 9'(o4_adv), 9'd0);
      check("rerun_s2_err", 9'(o2_err), 9'd0);
      check("rerun_s4_err", 9'(o4_err), 9'd0);

      repeat (2) @(negedge wrclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
